// File: rtl/zcd_window_integrator.sv
// -----------------------------------------------------------------------------
// zcd_window_integrator
//
// Integrates the ADC sample stream between the zero-crossing detector's window
// markers. For every window it produces the sum of samples, the sum of squared
// samples and the number of valid samples. Downstream logic uses these for
// RMS and energy. It also flags a disagreement with the detector's own count.
//
// Ports
//   clk                : single clock, rising edge
//   rst                : synchronous active-high reset
//   clear              : synchronous soft reset, same effect as rst
//   in_data            : signed ADC sample
//   in_data_valid      : in_data is valid this cycle
//   int_start          : window-open pulse from the detector
//   int_stop           : window-close pulse from the detector
//   in_number_samples  : detector's sample count for the window
//   in_number_valid    : one-cycle strobe that latches in_number_samples
//   out_sum_sq         : saturating sum of in_data^2 over the window
//   out_sum            : signed sum of in_data over the window
//   out_count          : number of valid samples in the window
//   out_valid          : one-cycle pulse; the three totals are new
//   out_overflow       : sum of squares or count saturated in this window
//   out_mismatch       : out_count differs from the latched detector count
//   busy               : a window is open or is being flushed
//
// Pipeline: stage 1 registers the sample and its square. Stage 2 adds them
// into the accumulators. The two FLUSH states let the last sample drain
// through stage 2. After that, DONE publishes the totals.
// -----------------------------------------------------------------------------
module zcd_window_integrator #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int ACC_WIDTH    = 48,
    parameter int SUM_WIDTH    = 40,
    parameter int REG_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [SAMPLE_WIDTH-1:0]     in_data,
    input  logic                        in_data_valid,
    input  logic                        int_start,
    input  logic                        int_stop,
    input  logic [REG_WIDTH-1:0]        in_number_samples,
    input  logic                        in_number_valid,
    output logic [ACC_WIDTH-1:0]        out_sum_sq,
    output logic signed [SUM_WIDTH-1:0] out_sum,
    output logic [REG_WIDTH-1:0]        out_count,
    output logic                        out_valid,
    output logic                        out_overflow,
    output logic                        out_mismatch,
    output logic                        busy
);

    // A square of an N-bit two's-complement value needs only 2N-1 bits.
    // The largest square is (-2^(N-1))^2 = 2^(2N-2).
    localparam int SQ_WIDTH = 2 * SAMPLE_WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH1,
        S_FLUSH2,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_take;
    logic                        w_rst;

    // Stage 1
    logic                        r_s1_vld;
    logic [SAMPLE_WIDTH-1:0]     r_s1_data;
    logic [SQ_WIDTH-1:0]         r_s1_sq;

    // Stage 2 accumulators
    logic [ACC_WIDTH-1:0]        r_acc_sq;
    logic signed [SUM_WIDTH-1:0] r_acc_sum;
    logic [REG_WIDTH-1:0]        r_acc_cnt;
    logic                        r_ovf;

    logic [REG_WIDTH-1:0]        r_num_lat;

    // Output registers
    logic [ACC_WIDTH-1:0]        r_out_sum_sq;
    logic signed [SUM_WIDTH-1:0] r_out_sum;
    logic [REG_WIDTH-1:0]        r_out_count;
    logic                        r_out_valid;
    logic                        r_out_overflow;
    logic                        r_out_mismatch;

    // Arithmetic nets
    logic signed [2*SAMPLE_WIDTH-1:0] w_sext;
    logic signed [2*SAMPLE_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH:0]               w_sq_sum;
    logic                             w_sq_sat;
    logic [ACC_WIDTH-1:0]             w_sq_nxt;
    logic signed [SUM_WIDTH-1:0]      w_data_ext;
    logic                             w_cnt_sat;
    logic [REG_WIDTH-1:0]             w_cnt_nxt;

    assign w_rst = rst | clear;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_take marks a sample that belongs to the window. The start cycle
    // counts. So does the stop cycle, because ACCUM is still current then.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A stop given together with the start is ignored here. It
                // only takes effect if it is asserted again from ACCUM.
                if (int_start) begin
                    w_state_nxt = S_ACCUM;
                    w_take      = in_data_valid;
                end
            end
            S_ACCUM: begin
                w_take = in_data_valid;
                if (int_stop) begin
                    w_state_nxt = S_FLUSH1;
                end
            end
            S_FLUSH1: w_state_nxt = S_FLUSH2;
            S_FLUSH2: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // --------------------------------------------------------- arithmetic
    // Sign-extend before multiplying so the product is computed at full
    // width. The low 2N-1 bits then give the non-negative square.
    assign w_sext = {{SAMPLE_WIDTH{in_data[SAMPLE_WIDTH-1]}}, in_data};
    assign w_prod = w_sext * w_sext;

    // The extra carry bit detects wrap-around of the sum of squares.
    assign w_sq_sum = {1'b0, r_acc_sq} + (ACC_WIDTH+1)'(r_s1_sq);
    assign w_sq_sat = w_sq_sum[ACC_WIDTH];
    assign w_sq_nxt = w_sq_sat ? {ACC_WIDTH{1'b1}} : w_sq_sum[ACC_WIDTH-1:0];

    assign w_data_ext = SUM_WIDTH'($signed(r_s1_data));

    assign w_cnt_sat = &r_acc_cnt;
    assign w_cnt_nxt = w_cnt_sat ? r_acc_cnt : r_acc_cnt + 1'b1;

    // ------------------------------------------------------------ stage 1
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_sq   <= '0;
        end else begin
            r_s1_vld  <= w_take;
            r_s1_data <= in_data;
            r_s1_sq   <= w_prod[SQ_WIDTH-1:0];
        end
    end

    // ------------------------------------------------ count latch
    // This value is kept across windows. A reset or clear zeroes it.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_num_lat <= '0;
        end else if (in_number_valid) begin
            r_num_lat <= in_number_samples;
        end
    end

    // ---------------------------------------- stage 2 and result publish
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_acc_sq       <= '0;
            r_acc_sum      <= '0;
            r_acc_cnt      <= '0;
            r_ovf          <= 1'b0;
            r_out_sum_sq   <= '0;
            r_out_sum      <= '0;
            r_out_count    <= '0;
            r_out_valid    <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_mismatch <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == S_DONE) begin
                r_out_sum_sq   <= r_acc_sq;
                r_out_sum      <= r_acc_sum;
                r_out_count    <= r_acc_cnt;
                r_out_overflow <= r_ovf;
                r_out_mismatch <= (r_acc_cnt != r_num_lat);
                r_out_valid    <= 1'b1;
                r_acc_sq       <= '0;
                r_acc_sum      <= '0;
                r_acc_cnt      <= '0;
                r_ovf          <= 1'b0;
            end else if (r_s1_vld) begin
                // A start-cycle sample reaches this stage when the state is
                // already ACCUM. So IDLE never sees a valid here.
                r_acc_sq  <= w_sq_nxt;
                r_acc_sum <= r_acc_sum + w_data_ext;
                r_acc_cnt <= w_cnt_nxt;
                if (w_sq_sat || w_cnt_sat) begin
                    r_ovf <= 1'b1;
                end
            end else if (r_state == S_IDLE) begin
                r_acc_sq  <= '0;
                r_acc_sum <= '0;
                r_acc_cnt <= '0;
                r_ovf     <= 1'b0;
            end
        end
    end

    assign out_sum_sq   = r_out_sum_sq;
    assign out_sum      = r_out_sum;
    assign out_count    = r_out_count;
    assign out_valid    = r_out_valid;
    assign out_overflow = r_out_overflow;
    assign out_mismatch = r_out_mismatch;
    assign busy         = (r_state != S_IDLE);

endmodule
